// File: rtl/deadtime_monitor_if.sv
// Signal bundle between a gate-drive source (master) and the deadtime monitor (slave).
interface deadtime_monitor_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 8,
  parameter int unsigned SW = 4
);
  logic [N-1:0]  hi_in;
  logic [N-1:0]  lo_in;
  logic          clear;
  logic [SW-1:0] sel;
  logic [CW-1:0] dt_last;
  logic [N-1:0]  dt_fault;
  logic [N-1:0]  st_fault;
  logic          fault_any;
  logic [N-1:0]  hi_rec;

  modport master (
    output hi_in, lo_in, clear, sel,
    input  dt_last, dt_fault, st_fault, fault_any, hi_rec
  );

  modport slave (
    input  hi_in, lo_in, clear, sel,
    output dt_last, dt_fault, st_fault, fault_any, hi_rec
  );
endinterface

// File: rtl/deadtime_monitor.sv
// Per-channel complementary gate-pair checker: measures both-off gaps at commutation,
// latches short-deadtime and shoot-through faults, and recovers the hi-side PWM.
module deadtime_monitor #(
  parameter int unsigned N      = 16,
  parameter int unsigned CW     = 8,
  parameter int unsigned MIN_DT = 25,
  parameter int unsigned SW     = 4
) (
  input logic               clk,
  input logic               rst_n,
  deadtime_monitor_if.slave bus
);

  typedef enum logic [2:0] {StInit, StOnHi, StOnLo, StGap, StOverlap} state_e;

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] MinDt  = CW'(MIN_DT);

  logic [N-1:0]  hi_s1_q, lo_s1_q, hi_s2_q, lo_s2_q;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [N-1:0]  from_hi_q, from_hi_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [CW-1:0] dt_q [N];
  logic [CW-1:0] dt_d [N];
  logic [N-1:0]  dt_fault_q, dt_fault_d, st_fault_q, st_fault_d;
  logic [N-1:0]  dt_set, st_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_s1_q    <= '0;
      lo_s1_q    <= '0;
      hi_s2_q    <= '0;
      lo_s2_q    <= '0;
      from_hi_q  <= '0;
      dt_fault_q <= '0;
      st_fault_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= StInit;
        cnt_q[i]   <= '0;
        dt_q[i]    <= '0;
      end
    end else begin
      hi_s1_q    <= bus.hi_in;
      lo_s1_q    <= bus.lo_in;
      hi_s2_q    <= hi_s1_q;
      lo_s2_q    <= lo_s1_q;
      from_hi_q  <= from_hi_d;
      dt_fault_q <= dt_fault_d;
      st_fault_q <= st_fault_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        dt_q[i]    <= dt_d[i];
      end
    end
  end

  always_comb begin
    from_hi_d = from_hi_q;
    dt_set    = '0;
    // Any simultaneous-on sample is a shoot-through, whatever the channel state.
    st_set    = hi_s2_q & lo_s2_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      dt_d[i]    = dt_q[i];
      case (state_q[i])
        StInit: begin
          case ({hi_s2_q[i], lo_s2_q[i]})
            2'b10:   state_d[i] = StOnHi;
            2'b01:   state_d[i] = StOnLo;
            2'b11:   state_d[i] = StOverlap;
            default: ;
          endcase
        end
        StOnHi: begin
          case ({hi_s2_q[i], lo_s2_q[i]})
            2'b00: begin
              state_d[i]   = StGap;
              from_hi_d[i] = 1'b1;
              cnt_d[i]     = CW'(1);
            end
            2'b01: begin
              state_d[i] = StOnLo;
              dt_d[i]    = '0;
              dt_set[i]  = 1'b1;
            end
            2'b11:   state_d[i] = StOverlap;
            default: ;
          endcase
        end
        StOnLo: begin
          case ({hi_s2_q[i], lo_s2_q[i]})
            2'b00: begin
              state_d[i]   = StGap;
              from_hi_d[i] = 1'b0;
              cnt_d[i]     = CW'(1);
            end
            2'b10: begin
              state_d[i] = StOnHi;
              dt_d[i]    = '0;
              dt_set[i]  = 1'b1;
            end
            2'b11:   state_d[i] = StOverlap;
            default: ;
          endcase
        end
        StGap: begin
          case ({hi_s2_q[i], lo_s2_q[i]})
            2'b00: begin
              if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CW'(1);
            end
            // Returning to the side we left is a dropped pulse, not a commutation.
            2'b10: begin
              state_d[i] = StOnHi;
              if (!from_hi_q[i]) begin
                dt_d[i]   = cnt_q[i];
                dt_set[i] = (cnt_q[i] < MinDt);
              end
            end
            2'b01: begin
              state_d[i] = StOnLo;
              if (from_hi_q[i]) begin
                dt_d[i]   = cnt_q[i];
                dt_set[i] = (cnt_q[i] < MinDt);
              end
            end
            default: state_d[i] = StOverlap;
          endcase
        end
        StOverlap: begin
          case ({hi_s2_q[i], lo_s2_q[i]})
            2'b10:   state_d[i] = StOnHi;
            2'b01:   state_d[i] = StOnLo;
            2'b00:   state_d[i] = StInit;
            default: ;
          endcase
        end
        default: state_d[i] = StInit;
      endcase
    end
  end

  // A detection on the same cycle as clear wins.
  always_comb begin
    dt_fault_d = (dt_fault_q & ~{N{bus.clear}}) | dt_set;
    st_fault_d = (st_fault_q & ~{N{bus.clear}}) | st_set;
  end

  always_comb begin
    bus.dt_last = '0;
    if (32'(bus.sel) < N) bus.dt_last = dt_q[bus.sel];
  end

  assign bus.dt_fault  = dt_fault_q;
  assign bus.st_fault  = st_fault_q;
  assign bus.fault_any = |{dt_fault_q, st_fault_q};
  assign bus.hi_rec    = hi_s2_q;

endmodule

// File: tb/tb_deadtime_monitor.sv
// Bench for deadtime_monitor: directed scenarios plus random gate traffic against a
// run-length model of the synchronised gate pairs.
module tb_deadtime_monitor;
  localparam int unsigned N      = 16;
  localparam int unsigned CW     = 8;
  localparam int unsigned MIN_DT = 25;
  localparam int unsigned SW     = 4;
  localparam int          GapMax = 255;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  deadtime_monitor_if #(.N(N), .CW(CW), .SW(SW)) bus ();

  deadtime_monitor #(.N(N), .CW(CW), .MIN_DT(MIN_DT), .SW(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model: each channel remembers the last side that was on alone (1 hi, 2 lo),
  // 0 for "no reference side", 3 for overlap, and the length of the current both-off run.
  logic [N-1:0] p1_h = '0, p1_l = '0, p2_h = '0, p2_l = '0;
  logic [N-1:0] m_dtf = '0, m_stf = '0, set_dt, set_st;
  int side [N];
  int gap  [N];
  int m_dt [N];
  int s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_h = '0; p1_l = '0; p2_h = '0; p2_l = '0;
      m_dtf = '0; m_stf = '0;
      for (int i = 0; i < N; i++) begin
        side[i] = 0; gap[i] = 0; m_dt[i] = 0;
      end
    end else begin
      set_dt = '0;
      set_st = '0;
      for (int i = 0; i < N; i++) begin
        if (p2_h[i] && p2_l[i]) begin
          set_st[i] = 1'b1;
          side[i]   = 3;
          gap[i]    = 0;
        end else if (!p2_h[i] && !p2_l[i]) begin
          if (side[i] == 1 || side[i] == 2) gap[i]++;
          else side[i] = 0;
        end else begin
          s = p2_h[i] ? 1 : 2;
          if ((side[i] == 1 || side[i] == 2) && side[i] != s) begin
            m_dt[i] = (gap[i] > GapMax) ? GapMax : gap[i];
            if (gap[i] < MIN_DT) set_dt[i] = 1'b1;
          end
          side[i] = s;
          gap[i]  = 0;
        end
      end
      m_dtf = (m_dtf & ~{N{bus.clear}}) | set_dt;
      m_stf = (m_stf & ~{N{bus.clear}}) | set_st;
      p2_h = p1_h; p2_l = p1_l;
      p1_h = bus.hi_in; p1_l = bus.lo_in;
    end
  end

  always @(negedge clk) begin
    check("dt_fault", 32'(bus.dt_fault), 32'(m_dtf));
    check("st_fault", 32'(bus.st_fault), 32'(m_stf));
    check("fault_any", 32'(bus.fault_any), 32'(|{m_dtf, m_stf}));
    check("hi_rec", 32'(bus.hi_rec), 32'(p2_h));
    check("dt_last", 32'(bus.dt_last), (32'(bus.sel) < N) ? 32'(m_dt[bus.sel]) : 32'd0);
  end

  int unsigned r;

  initial begin
    rst_n = 1'b1;
    bus.hi_in = '0;
    bus.lo_in = '0;
    bus.clear = 1'b0;
    bus.sel   = '0;
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_dt_fault", 32'(bus.dt_fault), 32'd0);
    check("rst_st_fault", 32'(bus.st_fault), 32'd0);
    check("rst_dt_last", 32'(bus.dt_last), 32'd0);

    // 1: legal 30-cycle gap on ch0
    bus.hi_in[0] = 1'b1; tick(4);
    bus.hi_in[0] = 1'b0; tick(30);
    bus.lo_in[0] = 1'b1; tick(4);
    check("t1_dt_last", 32'(bus.dt_last), 32'd30);
    check("t1_dt_fault0", 32'(bus.dt_fault[0]), 32'd0);
    check("t1_fault_any", 32'(bus.fault_any), 32'd0);
    check("t1_model_dt", 32'(m_dt[0]), 32'd30);

    // 2: short gap on ch3, flag exactly 3 clk after the lo edge, then clear
    bus.hi_in[3] = 1'b1; tick(4);
    bus.hi_in[3] = 1'b0; tick(10);
    bus.lo_in[3] = 1'b1; tick(2);
    check("t2_dt_fault3_early", 32'(bus.dt_fault[3]), 32'd0);
    tick(1);
    check("t2_dt_fault3", 32'(bus.dt_fault[3]), 32'd1);
    check("t2_fault_any", 32'(bus.fault_any), 32'd1);
    bus.clear = 1'b1; tick(1);
    bus.clear = 1'b0;
    check("t2_cleared", 32'(bus.dt_fault[3]), 32'd0);
    check("t2_any_cleared", 32'(bus.fault_any), 32'd0);

    // 3: one-cycle overlap on ch5
    bus.hi_in[5] = 1'b1; bus.lo_in[5] = 1'b1; tick(1);
    bus.hi_in[5] = 1'b0; bus.lo_in[5] = 1'b0; tick(1);
    check("t3_st_early", 32'(bus.st_fault), 32'd0);
    tick(1);
    check("t3_st_fault", 32'(bus.st_fault), 32'h0020);
    check("t3_dt_fault", 32'(bus.dt_fault), 32'd0);
    bus.clear = 1'b1; tick(1);
    bus.clear = 1'b0;

    // 4: 300-cycle gap on ch7 saturates
    bus.sel = SW'(7);
    bus.hi_in[7] = 1'b1; tick(4);
    bus.hi_in[7] = 1'b0; tick(300);
    bus.lo_in[7] = 1'b1; tick(4);
    check("t4_dt_last_sat", 32'(bus.dt_last), 32'd255);
    check("t4_dt_fault7", 32'(bus.dt_fault[7]), 32'd0);

    // 5: dropped hi pulse on ch2 leaves dt_last alone; clear collides with ch9 violation
    bus.sel = SW'(2);
    bus.hi_in[2] = 1'b1; tick(4);
    bus.hi_in[2] = 1'b0; tick(40);
    bus.lo_in[2] = 1'b1; tick(4);
    bus.lo_in[2] = 1'b0; tick(30);
    bus.hi_in[2] = 1'b1; tick(4);
    check("t5_dt_last_ref", 32'(bus.dt_last), 32'd30);
    bus.hi_in[2] = 1'b0; tick(5);
    bus.hi_in[2] = 1'b1; tick(4);
    check("t5_dt_last_kept", 32'(bus.dt_last), 32'd30);
    check("t5_dt_fault2", 32'(bus.dt_fault[2]), 32'd0);
    check("t5_hi_rec2", 32'(bus.hi_rec[2]), 32'd1);
    bus.hi_in[9] = 1'b1; tick(4);
    bus.hi_in[9] = 1'b0; tick(5);
    bus.lo_in[9] = 1'b1; tick(2);
    bus.clear = 1'b1; tick(1);
    bus.clear = 1'b0;
    check("t5_set_wins", 32'(bus.dt_fault), 32'h0200);

    // 6: reset mid-gap on ch1; first commutation after reset is unchecked
    bus.hi_in[1] = 1'b1; tick(4);
    bus.hi_in[1] = 1'b0; tick(5);
    rst_n = 1'b0; tick(1);
    check("t6_rst_dt_fault", 32'(bus.dt_fault), 32'd0);
    check("t6_rst_st_fault", 32'(bus.st_fault), 32'd0);
    check("t6_rst_any", 32'(bus.fault_any), 32'd0);
    check("t6_rst_hi_rec", 32'(bus.hi_rec), 32'd0);
    check("t6_rst_dt_last", 32'(bus.dt_last), 32'd0);
    rst_n = 1'b1;
    bus.sel = SW'(1);
    tick(3);
    bus.lo_in[1] = 1'b1; tick(4);
    check("t6_first_unchecked", 32'(bus.dt_fault), 32'd0);
    bus.lo_in[1] = 1'b0; tick(3);
    bus.hi_in[1] = 1'b1; tick(4);
    check("t6_second_fault", 32'(bus.dt_fault), 32'h0002);
    check("t6_dt_last", 32'(bus.dt_last), 32'd3);
    check("t6_model_dt", 32'(m_dt[1]), 32'd3);

    // Random gate traffic on all channels
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          r = $urandom_range(0, 3);
          if (r == 3 && $urandom_range(0, 3) != 0) r = 0;
          bus.hi_in[i] = r[1];
          bus.lo_in[i] = r[0];
        end
      end
      bus.clear = ($urandom_range(0, 63) == 0);
      bus.sel   = SW'($urandom_range(0, 15));
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick(1);
    end
    bus.clear = 1'b0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
